target_iomux_ctrl: RTL and testbench

TARGET_IOMUX_CTRL -- requirements
Module: target_iomux_ctrl

---
 rtl/target_iomux_pkg.sv | 24 ++
 rtl/target_iomux_pwrseq.sv | 73 +++++++
 rtl/target_iomux_ctrl.sv | 155 +++++++++++++++
 tb/tb_target_iomux_ctrl.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/target_iomux_pkg.sv
// Shared constants for the target IO mux: register map, per-pin mode codes
// and power sequencer state encodings.
package target_iomux_pkg;
  localparam logic [5:0] ADDR_MODE     = 6'd56;
  localparam logic [5:0] ADDR_POWER    = 6'd57;
  localparam logic [5:0] ADDR_NRSTLEN  = 6'd58;
  localparam logic [5:0] ADDR_NRSTGO   = 6'd59;
  localparam logic [5:0] ADDR_PINSTATE = 6'd60;

  typedef enum logic [2:0] {
    MODE_HIGHZ   = 3'd0,
    MODE_LOW     = 3'd1,
    MODE_HIGH    = 3'd2,
    MODE_UART_TX = 3'd3,
    MODE_UART_RX = 3'd4
  } io_mode_e;

  typedef enum logic [1:0] {
    PWR_OFF   = 2'd0,
    PWR_UP    = 2'd1,
    PWR_ON    = 2'd2,
    PWR_DRAIN = 2'd3
  } pwr_state_e;
endpackage

// File: rtl/target_iomux_pwrseq.sv
// Target power sequencer: settles after power-on before outputs may drive,
// and tristates outputs for a drain window before cutting power.
module target_iomux_pwrseq
  import target_iomux_pkg::*;
#(
  parameter int PWR_SETTLE   = 96000,
  parameter int DRAIN_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_pwr_req,
  output pwr_state_e o_state
);
  localparam int MAXC = (PWR_SETTLE > DRAIN_CYCLES) ? PWR_SETTLE : DRAIN_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(PWR_SETTLE - 1);
  localparam logic [CW-1:0] DRAIN_LAST  = CW'(DRAIN_CYCLES - 1);

  pwr_state_e    r_state, w_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= PWR_OFF;
      r_cnt   <= '0;
    end else begin
      r_state <= w_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Counter restarts from zero on every state change, so each timed state
  // lasts exactly its configured number of cycles.
  always_comb begin
    w_nxt     = r_state;
    w_cnt_nxt = r_cnt;
    case (r_state)
      PWR_OFF: if (i_pwr_req) begin
        w_nxt     = PWR_UP;
        w_cnt_nxt = '0;
      end
      PWR_UP: begin
        if (!i_pwr_req) begin
          w_nxt     = PWR_DRAIN;
          w_cnt_nxt = '0;
        end else if (r_cnt == SETTLE_LAST) begin
          w_nxt     = PWR_ON;
          w_cnt_nxt = '0;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      PWR_ON: if (!i_pwr_req) begin
        w_nxt     = PWR_DRAIN;
        w_cnt_nxt = '0;
      end
      PWR_DRAIN: begin
        if (r_cnt == DRAIN_LAST) begin
          w_nxt     = PWR_OFF;
          w_cnt_nxt = '0;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      default: begin
        w_nxt     = PWR_OFF;
        w_cnt_nxt = '0;
      end
    endcase
  end

  assign o_state = r_state;
endmodule

// File: rtl/target_iomux_ctrl.sv
// Target IO mux controller: per-pin mode mux, UART routing, power sequencing
// and nRST pulse. Define IOMUX_PINSTATE_EN to add the synchronised PINSTATE register.
module target_iomux_ctrl
  import target_iomux_pkg::*;
#(
  parameter int NUM_IO       = 4,
  parameter int PWR_SETTLE   = 96000,
  parameter int DRAIN_CYCLES = 16
) (
  input  logic              clk,
  input  logic              reset_i,
  input  logic [5:0]        reg_address,
  input  logic [15:0]       reg_bytecnt,
  input  logic [7:0]        reg_datai,
  output logic [7:0]        reg_datao,
  input  logic [15:0]       reg_size,
  input  logic              reg_read,
  input  logic              reg_write,
  input  logic              reg_addrvalid,
  input  logic [5:0]        reg_hypaddress,
  output logic [15:0]       reg_hyplen,
  input  logic [NUM_IO-1:0] io_in,
  output logic [NUM_IO-1:0] io_out,
  output logic [NUM_IO-1:0] io_oe,
  input  logic              uart_tx_i,
  output logic              uart_rx_o,
  output logic              nrst_out,
  output logic              nrst_oe,
  output logic              target_npower
);
  logic [NUM_IO-1:0][2:0] r_mode;
  logic                   r_pwr_req;
  logic [15:0]            r_nrst_len, r_nrst_cnt;
  logic [7:0]             r_datao;
  logic [7:0]             w_rd_byte, w_pin;
  logic                   w_wr, w_go, w_on, w_rx;
  logic [15:0]            w_pin_len;
  pwr_state_e             w_state;
  logic                   w_unused;

  assign w_unused = ^reg_size;
  assign w_wr     = reg_write && reg_addrvalid;
  assign w_go     = w_wr && (reg_address == ADDR_NRSTGO) && reg_datai[0];

  target_iomux_pwrseq #(.PWR_SETTLE(PWR_SETTLE), .DRAIN_CYCLES(DRAIN_CYCLES)) u_pwrseq (
    .clk       (clk),
    .rst       (reset_i),
    .i_pwr_req (r_pwr_req),
    .o_state   (w_state)
  );

  assign w_on          = (w_state == PWR_ON);
  assign target_npower = (w_state == PWR_OFF);

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      r_mode     <= '0;
      r_pwr_req  <= 1'b0;
      r_nrst_len <= '0;
    end else if (w_wr) begin
      case (reg_address)
        ADDR_MODE:
          for (int n = 0; n < NUM_IO; n++)
            if (reg_bytecnt == 16'(n)) r_mode[n] <= reg_datai[2:0];
        ADDR_POWER: r_pwr_req <= reg_datai[0];
        ADDR_NRSTLEN: begin
          if (reg_bytecnt == 16'd0) r_nrst_len[7:0]  <= reg_datai;
          if (reg_bytecnt == 16'd1) r_nrst_len[15:8] <= reg_datai;
        end
        default: ;
      endcase
    end
  end

  // Pulse counter is held at zero outside ON so a power-down aborts it.
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i)            r_nrst_cnt <= '0;
    else if (!w_on)         r_nrst_cnt <= '0;
    else if (w_go)          r_nrst_cnt <= r_nrst_len;
    else if (r_nrst_cnt != '0) r_nrst_cnt <= r_nrst_cnt - 16'd1;
  end

  assign nrst_oe  = w_on && (r_nrst_cnt != '0);
  assign nrst_out = !nrst_oe;

  for (genvar n = 0; n < NUM_IO; n++) begin : g_io
    assign io_oe[n]  = w_on && ((r_mode[n] == MODE_LOW) || (r_mode[n] == MODE_HIGH) ||
                                (r_mode[n] == MODE_UART_TX));
    assign io_out[n] = (r_mode[n] == MODE_HIGH) || ((r_mode[n] == MODE_UART_TX) && uart_tx_i);
  end

  always_comb begin
    w_rx = 1'b1;
    for (int n = 0; n < NUM_IO; n++)
      if (r_mode[n] == MODE_UART_RX) w_rx = w_rx & io_in[n];
  end
  assign uart_rx_o = w_rx;

`ifdef IOMUX_PINSTATE_EN
  logic [NUM_IO-1:0] r_sync1, r_sync2;
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= io_in;
      r_sync2 <= r_sync1;
    end
  end
  always_comb begin
    w_pin              = '0;
    w_pin[NUM_IO-1:0]  = r_sync2;
  end
  assign w_pin_len = 16'd1;
`else
  assign w_pin     = '0;
  assign w_pin_len = 16'd0;
`endif

  always_comb begin
    w_rd_byte = '0;
    case (reg_address)
      ADDR_MODE:
        for (int n = 0; n < NUM_IO; n++)
          if (reg_bytecnt == 16'(n)) w_rd_byte = {5'b0, r_mode[n]};
      ADDR_POWER:   if (reg_bytecnt == 16'd0) w_rd_byte = {5'b0, w_state, r_pwr_req};
      ADDR_NRSTLEN: begin
        if (reg_bytecnt == 16'd0) w_rd_byte = r_nrst_len[7:0];
        if (reg_bytecnt == 16'd1) w_rd_byte = r_nrst_len[15:8];
      end
      ADDR_PINSTATE: if (reg_bytecnt == 16'd0) w_rd_byte = w_pin;
      default: ;
    endcase
  end

  // Unselected reads return zero so several blocks can share an OR'd bus.
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i)                        r_datao <= '0;
    else if (reg_read && reg_addrvalid) r_datao <= w_rd_byte;
    else                                r_datao <= '0;
  end
  assign reg_datao = r_datao;

  always_comb begin
    reg_hyplen = '0;
    case (reg_hypaddress)
      ADDR_MODE:     reg_hyplen = 16'(NUM_IO);
      ADDR_POWER:    reg_hyplen = 16'd1;
      ADDR_NRSTLEN:  reg_hyplen = 16'd2;
      ADDR_NRSTGO:   reg_hyplen = 16'd1;
      ADDR_PINSTATE: reg_hyplen = w_pin_len;
      default: ;
    endcase
  end
endmodule

// File: tb/tb_target_iomux_ctrl.sv
// Directed bench for target_iomux_ctrl: register table plus hand-timed
// power, drain, nRST pulse and async-reset sequences.
module tb_target_iomux_ctrl;
  logic        clk = 1'b0;
  logic        reset_i = 1'b1;
  logic [5:0]  reg_address = '0;
  logic [15:0] reg_bytecnt = '0;
  logic [7:0]  reg_datai = '0;
  logic [7:0]  reg_datao;
  logic [15:0] reg_size = '0;
  logic        reg_read = 1'b0;
  logic        reg_write = 1'b0;
  logic        reg_addrvalid = 1'b0;
  logic [5:0]  reg_hypaddress = '0;
  logic [15:0] reg_hyplen;
  logic [3:0]  io_in = '0;
  logic [3:0]  io_out, io_oe;
  logic        uart_tx_i = 1'b0;
  logic        uart_rx_o, nrst_out, nrst_oe, target_npower;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  target_iomux_ctrl #(.NUM_IO(4), .PWR_SETTLE(10), .DRAIN_CYCLES(16)) dut (
    .clk(clk), .reset_i(reset_i), .reg_address(reg_address), .reg_bytecnt(reg_bytecnt),
    .reg_datai(reg_datai), .reg_datao(reg_datao), .reg_size(reg_size), .reg_read(reg_read),
    .reg_write(reg_write), .reg_addrvalid(reg_addrvalid), .reg_hypaddress(reg_hypaddress),
    .reg_hyplen(reg_hyplen), .io_in(io_in), .io_out(io_out), .io_oe(io_oe),
    .uart_tx_i(uart_tx_i), .uart_rx_o(uart_rx_o), .nrst_out(nrst_out), .nrst_oe(nrst_oe),
    .target_npower(target_npower)
  );

  typedef struct {
    bit          wr;
    logic [5:0]  addr;
    logic [15:0] bc;
    logic [7:0]  data;
    logic [7:0]  exp;
    logic [15:0] hyp;
  } vec_t;
  vec_t vt[15];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  task automatic wr(input logic [5:0] a, input logic [15:0] bc, input logic [7:0] d);
    @(negedge clk);
    reg_address = a; reg_bytecnt = bc; reg_datai = d;
    reg_write = 1'b1; reg_addrvalid = 1'b1;
    @(negedge clk);
    reg_write = 1'b0; reg_addrvalid = 1'b0;
  endtask

  task automatic rd(input logic [5:0] a, input logic [15:0] bc, output logic [7:0] d);
    @(negedge clk);
    reg_address = a; reg_bytecnt = bc;
    reg_read = 1'b1; reg_addrvalid = 1'b1;
    @(negedge clk);
    d = reg_datao;
    reg_read = 1'b0; reg_addrvalid = 1'b0;
  endtask

  // Fires NRSTGO=1, then counts nrst_oe cycles; optionally writes (a2,d2)
  // while the 'at'-th pulse cycle is current.
  task automatic pulse_run(input int at, input logic [5:0] a2, input logic [7:0] d2,
                           output int n, output int bad_out);
    n = 0; bad_out = 0;
    @(negedge clk);
    reg_address = 6'd59; reg_bytecnt = '0; reg_datai = 8'd1;
    reg_write = 1'b1; reg_addrvalid = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      reg_write = 1'b0; reg_addrvalid = 1'b0;
      if (nrst_oe) n++;
      if (nrst_oe == nrst_out) bad_out++;
      if (i == at) begin
        reg_address = a2; reg_bytecnt = '0; reg_datai = d2;
        reg_write = 1'b1; reg_addrvalid = 1'b1;
      end
    end
  endtask

  initial begin
    logic [7:0] d;
    int n, bo, bad, first1, n1, firstoe;
    logic [3:0] oe1;
    logic [7:0] pin_exp;
    logic [15:0] pin_hyp;

    vt[0]  = '{1'b1, 6'd56, 16'd0, 8'd2, 8'd0, 16'd0};
    vt[1]  = '{1'b1, 6'd56, 16'd1, 8'd3, 8'd0, 16'd0};
    vt[2]  = '{1'b1, 6'd56, 16'd2, 8'd4, 8'd0, 16'd0};
    vt[3]  = '{1'b1, 6'd56, 16'd3, 8'd4, 8'd0, 16'd0};
    vt[4]  = '{1'b1, 6'd56, 16'd4, 8'd1, 8'd0, 16'd0};
    vt[5]  = '{1'b0, 6'd56, 16'd0, 8'd0, 8'd2, 16'd4};
    vt[6]  = '{1'b0, 6'd56, 16'd1, 8'd0, 8'd3, 16'd4};
    vt[7]  = '{1'b0, 6'd56, 16'd2, 8'd0, 8'd4, 16'd4};
    vt[8]  = '{1'b0, 6'd56, 16'd3, 8'd0, 8'd4, 16'd4};
    vt[9]  = '{1'b1, 6'd58, 16'd0, 8'd5, 8'd0, 16'd0};
    vt[10] = '{1'b1, 6'd58, 16'd1, 8'd0, 8'd0, 16'd0};
    vt[11] = '{1'b0, 6'd58, 16'd0, 8'd0, 8'd5, 16'd2};
    vt[12] = '{1'b0, 6'd58, 16'd1, 8'd0, 8'd0, 16'd2};
    vt[13] = '{1'b0, 6'd59, 16'd0, 8'd0, 8'd0, 16'd1};
    vt[14] = '{1'b0, 6'd0,  16'd0, 8'd0, 8'd0, 16'd0};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_npower", target_npower, 1);
    chk("rst_oe", io_oe, 0);
    chk("rst_out", io_out, 0);
    chk("rst_nrst", {nrst_oe, nrst_out}, 2'b01);
    chk("rst_datao", reg_datao, 0);
    chk("rst_uart_rx_none", uart_rx_o, 1);
    reset_i = 1'b0;
    rd(6'd57, 0, d);
    chk("rst_power_rd", d, 8'h00);
    reg_hypaddress = 6'd57; #1;
    chk("hyp_power", reg_hyplen, 1);

    foreach (vt[i]) begin
      if (vt[i].wr) wr(vt[i].addr, vt[i].bc, vt[i].data);
      else begin
        reg_hypaddress = vt[i].addr; #1;
        chk($sformatf("vec%0d_hyp", i), reg_hyplen, vt[i].hyp);
        rd(vt[i].addr, vt[i].bc, d);
        chk($sformatf("vec%0d_rd", i), d, vt[i].exp);
      end
    end

    // UART RX routing, ch2/ch3 in RX mode
    io_in = 4'b1000; #1;
    chk("uart_rx_10", uart_rx_o, 0);
    io_in = 4'b1100; #1;
    chk("uart_rx_11", uart_rx_o, 1);

    // Power up: 10 settle cycles with outputs off
    wr(6'd57, 0, 1);
    chk("pwr_off_before", target_npower, 1);
    bad = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (io_oe != 0 || target_npower != 0) bad++;
    end
    chk("pwrup_oe_low", bad, 0);
    @(negedge clk);
    chk("on_oe", io_oe, 4'b0011);
    chk("on_out0", io_out[0], 1);
    uart_tx_i = 1'b0; #1;
    chk("on_tx0", io_out[1], 0);
    uart_tx_i = 1'b1; #1;
    chk("on_tx1", io_out[1], 1);
    uart_tx_i = 1'b0;
    rd(6'd57, 0, d);
    chk("on_power_rd", d, 8'h05);

    // nRST pulses
    pulse_run(0, 6'd0, 8'd0, n, bo);
    chk("pulse_len5", n, 5);
    chk("pulse_level", bo, 0);
    pulse_run(3, 6'd59, 8'd1, n, bo);
    chk("pulse_retrig", n, 8);
    wr(6'd58, 0, 0);
    pulse_run(0, 6'd0, 8'd0, n, bo);
    chk("pulse_len0", n, 0);
    wr(6'd58, 0, 5);
    pulse_run(2, 6'd57, 8'd0, n, bo);
    chk("pulse_abort", n, 3);
    chk("abort_off_npower", target_npower, 1);
    rd(6'd57, 0, d);
    chk("abort_power_rd", d, 8'h00);
    pulse_run(0, 6'd0, 8'd0, n, bo);
    chk("pulse_when_off", n, 0);

    // Re-power, then drop power and re-request during DRAIN
    wr(6'd57, 0, 1);
    repeat (11) @(negedge clk);
    chk("repower_oe", io_oe, 4'b0011);
    wr(6'd57, 0, 0);
    first1 = -1; n1 = 0; firstoe = -1; oe1 = '0;
    for (int j = 1; j <= 40; j++) begin
      @(negedge clk);
      reg_write = 1'b0; reg_addrvalid = 1'b0;
      if (j == 1) begin
        chk("drain_oe", io_oe, 0);
        chk("drain_npower", target_npower, 0);
      end
      if (target_npower) begin
        n1++;
        if (first1 < 0) first1 = j;
      end
      if (io_oe != 0 && firstoe < 0) begin
        firstoe = j; oe1 = io_oe;
      end
      if (j == 4) begin
        reg_address = 6'd57; reg_bytecnt = '0; reg_datai = 8'd1;
        reg_write = 1'b1; reg_addrvalid = 1'b1;
      end
    end
    chk("drain_off_at", first1, 17);
    chk("drain_off_len", n1, 1);
    chk("drain_reon_at", firstoe, 28);
    chk("drain_reon_oe", oe1, 4'b0011);

    // PINSTATE
`ifdef IOMUX_PINSTATE_EN
    pin_exp = 8'h05; pin_hyp = 16'd1;
`else
    pin_exp = 8'h00; pin_hyp = 16'd0;
`endif
    io_in = 4'h5;
    repeat (3) @(negedge clk);
    rd(6'd60, 0, d);
    chk("pinstate_rd", d, pin_exp);
    reg_hypaddress = 6'd60; #1;
    chk("pinstate_hyp", reg_hyplen, pin_hyp);

    // Async reset in the middle of a pulse
    @(negedge clk);
    reg_address = 6'd59; reg_bytecnt = '0; reg_datai = 8'd1;
    reg_write = 1'b1; reg_addrvalid = 1'b1;
    @(negedge clk);
    reg_write = 1'b0; reg_addrvalid = 1'b0;
    chk("pre_rst_pulse", nrst_oe, 1);
    #2 reset_i = 1'b1;
    #1;
    chk("arst_nrst", {nrst_oe, nrst_out}, 2'b01);
    chk("arst_npower", target_npower, 1);
    chk("arst_oe", io_oe, 0);
    chk("arst_out", io_out, 0);
    @(negedge clk);
    reset_i = 1'b0;
    rd(6'd57, 0, d);
    chk("arst_power_rd", d, 8'h00);
    rd(6'd56, 0, d);
    chk("arst_mode_rd", d, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
